// File: rtl/dcache_wt_if.sv
// Bundles the core request/response bus and the backing-memory handshake of the cache.
// The cache is the slave; the core plus data memory form the master side.
interface dcache_wt_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_we;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic [WIDTH-1:0] resp_rdata;
  logic             stall;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_rvalid;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  resp_rdata, stall,
    input  mem_req_valid, mem_we, mem_addr, mem_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output resp_rdata, stall,
    output mem_req_valid, mem_we, mem_addr, mem_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Load hits answer combinationally; misses and all stores stall while memory is accessed.
module dcache_wt #(
  parameter int SETS  = 16,
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  dcache_wt_if.slave    bus,
  output logic [15:0]   hit_count,
  output logic [15:0]   miss_count
);
  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = WIDTH - IDX - 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    RD_RESP = 3'd3,
    WR_REQ  = 3'd4,
    WR_DONE = 3'd5
  } state_t;

  state_t state_reg, state_next;

  logic [SETS-1:0]  valid_reg;
  logic [SETS-1:0]  fill_sel;
  logic [TAGW-1:0]  tag_mem  [SETS];
  logic [WIDTH-1:0] data_mem [SETS];
  logic [WIDTH-1:0] rdata_reg;
  logic [15:0]      hit_count_reg;
  logic [15:0]      miss_count_reg;

  logic [IDX-1:0]   index;
  logic [TAGW-1:0]  tag;
  logic             hit;
  logic             load_hit;
  logic             load_miss;
  logic             fill_en;
  logic             wr_hit_en;
  logic             unused_ok;

  assign index     = bus.req_addr[IDX+1:2];
  assign tag       = bus.req_addr[WIDTH-1:IDX+2];
  assign hit       = valid_reg[index] && (tag_mem[index] == tag);
  assign load_hit  = (state_reg == IDLE) && bus.req_valid && !bus.req_we && hit;
  assign load_miss = (state_reg == IDLE) && bus.req_valid && !bus.req_we && !hit;
  assign fill_en   = (state_reg == RD_WAIT) && bus.mem_rvalid;
  // A store only touches the line if it already holds this address (no allocate).
  assign wr_hit_en = (state_reg == WR_REQ) && bus.mem_req_ready && hit;

  assign bus.mem_addr  = {bus.req_addr[WIDTH-1:2], 2'b00};
  assign bus.mem_wdata = bus.req_wdata;
  assign hit_count     = hit_count_reg;
  assign miss_count    = miss_count_reg;
  assign unused_ok     = &{1'b0, bus.req_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we) begin
            state_next = WR_REQ;
          end else if (!hit) begin
            state_next = RD_REQ;
          end
        end
      end
      RD_REQ:  if (bus.mem_req_ready) state_next = RD_WAIT;
      RD_WAIT: if (bus.mem_rvalid)    state_next = RD_RESP;
      RD_RESP: state_next = IDLE;
      WR_REQ:  if (bus.mem_req_ready) state_next = WR_DONE;
      WR_DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.stall         = 1'b0;
    bus.mem_req_valid = 1'b0;
    bus.mem_we        = 1'b0;
    bus.resp_rdata    = '0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_we || !hit) begin
            bus.stall = 1'b1;
          end else begin
            bus.resp_rdata = data_mem[index];
          end
        end
      end
      RD_REQ: begin
        bus.stall         = 1'b1;
        bus.mem_req_valid = 1'b1;
      end
      RD_WAIT: bus.stall = 1'b1;
      RD_RESP: bus.resp_rdata = rdata_reg;
      WR_REQ: begin
        bus.stall         = 1'b1;
        bus.mem_req_valid = 1'b1;
        bus.mem_we        = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < SETS; gi++) begin : g_fill_sel
    assign fill_sel[gi] = fill_en && (index == IDX'(gi));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_reg | fill_sel;
    end
  end

  // Tag and data storage carries no reset; the valid bits alone qualify it.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]  <= tag;
      data_mem[index] <= bus.mem_rdata;
    end else if (wr_hit_en) begin
      data_mem[index] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_reg      <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (fill_en) begin
        rdata_reg <= bus.mem_rdata;
      end
      if (load_hit) begin
        hit_count_reg <= hit_count_reg + 16'd1;
      end
      if (load_miss) begin
        miss_count_reg <= miss_count_reg + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_dcache_wt.sv
// Bench for dcache_wt: directed vector table, reset/stray-rvalid sequence, then random
// traffic checked against an address-level cache model with a scripted memory responder.
module tb_dcache_wt;
  localparam int SETS  = 16;
  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  dcache_wt_if #(.WIDTH(WIDTH)) bus ();

  dcache_wt #(.SETS(SETS), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory responder controls and observations
  int          rdy_dly = 0;
  int          rv_dly  = 0;
  int          stray_seq = 0;
  int          txn_count = 0;
  bit          last_we;
  logic [31:0] last_addr;
  logic [31:0] last_wdata;
  logic [31:0] mem_q [int unsigned];

  // Reference model state
  bit          m_valid [SETS];
  int unsigned m_waddr [SETS];
  logic [31:0] m_data  [SETS];
  logic [31:0] ref_mem [int unsigned];
  logic [15:0] m_hits;
  logic [15:0] m_misses;

  function automatic logic [31:0] init_word(input int unsigned wa);
    if (wa == 32'h40) return 32'hDEADBEEF;
    if (wa == 32'h50) return 32'hCAFEF00D;
    return (wa * 32'h9E3779B1) ^ 32'h0000_1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  initial begin : responder
    int          rdy_cnt = 0;
    int          rv_cnt = 0;
    bit          pend = 0;
    bit          offered = 0;
    bit          off_we = 0;
    logic [31:0] off_addr = 0;
    logic [31:0] off_wdata = 0;
    int unsigned pend_wa = 0;
    int          stray_seen = 0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 0; offered = 0; rdy_cnt = 0; rv_cnt = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
      end else begin
        if (bus.mem_rvalid) pend = 0;
        if (offered) begin
          txn_count++;
          last_we = off_we; last_addr = off_addr; last_wdata = off_wdata;
          if (off_we) begin
            mem_q[off_addr >> 2] = off_wdata;
          end else begin
            pend = 1; rv_cnt = 0; pend_wa = off_addr >> 2;
          end
        end
        offered = 0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rvalid    = 1'b0;
        bus.mem_rdata     = '0;
        if (stray_seq != stray_seen) begin
          stray_seen = stray_seq;
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata  = 32'hBAD0BAD0;
        end else if (pend) begin
          if (rv_cnt >= rv_dly) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = mem_q.exists(pend_wa) ? mem_q[pend_wa] : init_word(pend_wa);
          end else begin
            rv_cnt++;
          end
        end else if (bus.mem_req_valid) begin
          if (rdy_cnt >= rdy_dly) begin
            bus.mem_req_ready = 1'b1;
            offered = 1; rdy_cnt = 0;
            off_we = bus.mem_we; off_addr = bus.mem_addr; off_wdata = bus.mem_wdata;
          end else begin
            rdy_cnt++;
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < SETS; i++) m_valid[i] = 0;
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input int rdy, input int rv, output logic [31:0] exp_rdata,
                              output int exp_cycles, output int exp_ntx);
    int unsigned wa = addr >> 2;
    int          idx = int'(wa % SETS);
    bit          is_hit = m_valid[idx] && (m_waddr[idx] == wa);
    exp_rdata = '0;
    if (we) begin
      ref_mem[wa] = wdata;
      if (is_hit) m_data[idx] = wdata;
      exp_cycles = 3 + rdy;
      exp_ntx = 1;
    end else if (is_hit) begin
      exp_rdata = m_data[idx];
      exp_cycles = 1;
      exp_ntx = 0;
      m_hits++;
    end else begin
      exp_rdata = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
      m_valid[idx] = 1; m_waddr[idx] = wa; m_data[idx] = exp_rdata;
      exp_cycles = 4 + rdy + rv;
      exp_ntx = 1;
      m_misses++;
    end
  endtask

  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output int cycles);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    cycles = 0;
    rdata = '0;
    forever begin
      #1;
      cycles++;
      if (bus.mem_req_valid) begin
        check("mem_addr", bus.mem_addr, {addr[31:2], 2'b00});
        check("mem_we", 32'(bus.mem_we), 32'(we));
        if (we) check("mem_wdata", bus.mem_wdata, wdata);
      end
      if (!bus.stall) begin
        rdata = bus.resp_rdata;
        break;
      end
      if (cycles >= 100) begin
        checks++; errors++;
        $display("FAIL timeout: stall still high after %0d cycles, required to drop", cycles);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0;
  endtask

  task automatic verify(input string tag, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int rdy, input int rv,
                        input logic [31:0] exp_rdata, input int exp_cycles, input int exp_ntx,
                        input logic [15:0] exp_h, input logic [15:0] exp_m);
    logic [31:0] rdata;
    int          cycles;
    int          tx0;
    rdy_dly = rdy; rv_dly = rv;
    tx0 = txn_count;
    do_access(we, addr, wdata, rdata, cycles);
    $display("%s %s addr=%h wdata=%h rdata=%h cycles=%0d hits=%0d misses=%0d",
             tag, we ? "ST" : "LD", addr, wdata, rdata, cycles, hit_count, miss_count);
    if (!we) check({tag, " rdata"}, rdata, exp_rdata);
    check({tag, " cycles"}, 32'(cycles), 32'(exp_cycles));
    check({tag, " mem txns"}, 32'(txn_count - tx0), 32'(exp_ntx));
    if (exp_ntx != 0 && txn_count != tx0) begin
      check({tag, " txn we"}, 32'(last_we), 32'(we));
      check({tag, " txn addr"}, last_addr, {addr[31:2], 2'b00});
      if (we) check({tag, " txn wdata"}, last_wdata, wdata);
    end
    check({tag, " hit_count"}, 32'(hit_count), 32'(exp_h));
    check({tag, " miss_count"}, 32'(miss_count), 32'(exp_m));
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          rdy;
    int          rv;
    logic [31:0] exp_rdata;
    int          exp_cycles;
    bit          exp_hit;
    logic [15:0] exp_h;
    logic [15:0] exp_m;
  } vec_t;

  vec_t vecs [14];

  initial begin : main
    logic [31:0] e_rd;
    int          e_cyc;
    int          e_ntx;
    vecs[0]  = '{1'b0, 32'h100, 32'h0,        0, 1, 32'hDEADBEEF, 5, 1'b0, 16'd0, 16'd1};
    vecs[1]  = '{1'b0, 32'h100, 32'h0,        0, 0, 32'hDEADBEEF, 1, 1'b1, 16'd1, 16'd1};
    vecs[2]  = '{1'b1, 32'h100, 32'h12345678, 0, 0, 32'h0,        3, 1'b1, 16'd1, 16'd1};
    vecs[3]  = '{1'b0, 32'h100, 32'h0,        0, 0, 32'h12345678, 1, 1'b1, 16'd2, 16'd1};
    vecs[4]  = '{1'b0, 32'h140, 32'h0,        0, 0, 32'hCAFEF00D, 4, 1'b0, 16'd2, 16'd2};
    vecs[5]  = '{1'b0, 32'h100, 32'h0,        1, 2, 32'h12345678, 7, 1'b0, 16'd2, 16'd3};
    vecs[6]  = '{1'b0, 32'h140, 32'h0,        0, 0, 32'hCAFEF00D, 4, 1'b0, 16'd2, 16'd4};
    vecs[7]  = '{1'b1, 32'h200, 32'hA5A5A5A5, 5, 0, 32'h0,        8, 1'b0, 16'd2, 16'd4};
    vecs[8]  = '{1'b0, 32'h140, 32'h0,        0, 0, 32'hCAFEF00D, 1, 1'b1, 16'd3, 16'd4};
    vecs[9]  = '{1'b0, 32'h200, 32'h0,        0, 0, 32'hA5A5A5A5, 4, 1'b0, 16'd3, 16'd5};
    vecs[10] = '{1'b0, 32'h200, 32'h0,        0, 0, 32'hA5A5A5A5, 1, 1'b1, 16'd4, 16'd5};
    vecs[11] = '{1'b1, 32'h104, 32'h0BADF00D, 2, 0, 32'h0,        5, 1'b0, 16'd4, 16'd5};
    vecs[12] = '{1'b0, 32'h104, 32'h0,        0, 0, 32'h0BADF00D, 4, 1'b0, 16'd4, 16'd6};
    vecs[13] = '{1'b0, 32'h107, 32'h0,        0, 0, 32'h0BADF00D, 1, 1'b1, 16'd5, 16'd6};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("reset resp_rdata", bus.resp_rdata, 32'h0);
    check("reset hit_count", 32'(hit_count), 32'd0);
    check("reset miss_count", 32'(miss_count), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      model_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy, vecs[i].rv,
                   e_rd, e_cyc, e_ntx);
      verify($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdy, vecs[i].rv, vecs[i].exp_rdata, vecs[i].exp_cycles,
             (vecs[i].we || !vecs[i].exp_hit) ? 1 : 0, vecs[i].exp_h, vecs[i].exp_m);
    end

    // Reset while a read waits for memory, then a stray rvalid.
    rdy_dly = 0; rv_dly = 20;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h100;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rd_wait stall", 32'(bus.stall), 32'd1);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check("midreset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("midreset stall", 32'(bus.stall), 32'd0);
    check("midreset miss_count", 32'(miss_count), 32'd0);
    check("midreset hit_count", 32'(hit_count), 32'd0);
    $display("reset asserted during RD_WAIT");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #2;
    stray_seq++;
    @(negedge clk);
    @(posedge clk);
    #1;
    check("stray stall", 32'(bus.stall), 32'd0);
    check("stray mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
    check("stray resp_rdata", bus.resp_rdata, 32'h0);
    $display("stray mem_rvalid issued");
    model_access(1'b0, 32'h100, 32'h0, 0, 0, e_rd, e_cyc, e_ntx);
    verify("post-reset", 1'b0, 32'h100, 32'h0, 0, 0, e_rd, e_cyc, e_ntx, m_hits, m_misses);

    for (int n = 0; n < 300; n++) begin
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          rdy;
      int          rv;
      we    = ($urandom_range(0, 99) < 30);
      addr  = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h0;
      addr  = addr | (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(0, 3));
      wdata = $urandom;
      rdy   = $urandom_range(0, 3);
      rv    = $urandom_range(0, 3);
      model_access(we, addr, wdata, rdy, rv, e_rd, e_cyc, e_ntx);
      verify($sformatf("rnd%0d", n), we, addr, wdata, rdy, rv, e_rd, e_cyc, e_ntx,
             m_hits, m_misses);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_wt.md
# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the backing data memory. Read hits return data combinationally in the request cycle. Misses and all writes stall the core while a valid/ready transaction runs on the memory side. Hit and miss counters are exposed for performance tests.

## Interface
- `SETS`, 16: number of one-word lines; power of two, ≥2. `IDX = log2(SETS)`.
- `WIDTH`, 32: data and address width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: core memory-stage access present.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in WIDTH: byte address; bits [1:0] ignored.
- `req_wdata` in WIDTH: store data.
- `resp_rdata` out WIDTH: load data, valid when `req_valid & !req_we & !stall`.
- `stall` out 1: core holds the pipeline and the request stable while high.
- `mem_req_valid` out 1: memory transaction request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_we` out 1: memory write.
- `mem_addr` out WIDTH: `{req_addr[WIDTH-1:2],2'b00}`.
- `mem_wdata` out WIDTH: equals `req_wdata`.
- `mem_rvalid` in 1: read data returned. Asserted one or more cycles after acceptance.
- `mem_rdata` in WIDTH: returned read data.
- `hit_count` out 16: loads that hit; wraps at 0xFFFF→0.
- `miss_count` out 16: loads that missed; wraps.

## Operation
- Address split: index = `req_addr[IDX+1:2]`; tag = `req_addr[WIDTH-1:IDX+2]`. Per line: valid bit, tag, data word.
- hit = `valid[index] & (tag_array[index] == tag)`.
- FSM states: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_REQ, WR_DONE.
- IDLE:
  - No request: `stall=0`.
  - Load hit: `stall=0`, `resp_rdata = data[index]`, `hit_count++`, stay in IDLE.
  - Load miss: `stall=1`, `miss_count++`, go to RD_REQ.
  - Store: `stall=1`, go to WR_REQ.
- RD_REQ: `mem_req_valid=1`, `mem_we=0`. On `mem_req_ready`, go to RD_WAIT.
- RD_WAIT: `stall=1`. On `mem_rvalid`: write data, tag and valid into the line; register `mem_rdata`; go to RD_RESP.
- RD_RESP: `stall=0`, `resp_rdata` = registered word. Go to IDLE; the request is not re-evaluated.
- WR_REQ: `mem_req_valid=1`, `mem_we=1`. On `mem_req_ready`:
  - if hit, update `data[index]` with `req_wdata`;
  - on a miss, the line is unchanged;
  - go to WR_DONE.
- WR_DONE: `stall=0`, go to IDLE.
- `stall` is high in RD_REQ, RD_WAIT and WR_REQ, and high combinationally in IDLE for a miss or store. It is low otherwise.
- `mem_req_valid` stays high until the handshake completes. `mem_addr`, `mem_we` and `mem_wdata` are stable while it is high.
- Outside RD_REQ/WR_REQ: `mem_req_valid=0`.
- `resp_rdata` is don't-care when not a valid load response. The implementation drives 0.
- A `mem_rvalid` outside RD_WAIT is ignored.

## Timing
- Reset (async assert, sync release):
  - state = IDLE;
  - all valid bits = 0;
  - counters = 0;
  - read-data register = 0;
  - `stall` = 0 when `req_valid=0`.
- Tag and data arrays are not reset.
- Load hit: 0 extra cycles.
- Load miss: `stall` is high from the request cycle through the `mem_rvalid` cycle. Data appears in RD_RESP, the cycle after `mem_rvalid`.
  - Minimum 4 cycles total, with ready in the first RD_REQ cycle and rvalid in the first RD_WAIT cycle.
- Store: minimum 3 cycles (IDLE, WR_REQ, WR_DONE).
- Counters increment on the clock edge leaving IDLE for misses, or in the hit cycle for hits.
- Reset asserted mid-transaction:
  - FSM returns to IDLE at once;
  - `mem_req_valid` drops asynchronously;
  - a later `mem_rvalid` is ignored;
  - the cache is empty.
- Store to a line that aliases a valid line with a different tag is a store miss: the existing line is untouched.

## Test plan
- Cold read: after reset, load 0x100.
  - `stall` is high; `mem_req_valid` with `mem_addr=0x100`.
  - Ready in 1 cycle; rvalid 2 cycles later with 0xDEADBEEF.
  - `resp_rdata=0xDEADBEEF` in RD_RESP; `miss_count=1`.
- Re-read of 0x100: `stall=0` in the same cycle, `resp_rdata=0xDEADBEEF`, no memory request, `hit_count=1`.
- Store hit, 0x100 ← 0x12345678:
  - `mem_we=1`, `mem_wdata=0x12345678`;
  - after WR_DONE, a load of 0x100 hits with 0x12345678.
- Conflict (SETS=16): load 0x140, which has the same index as 0x100.
  - Miss; line replaced.
  - A load of 0x100 then misses again; `miss_count=3`.
- Store miss to 0x200 with ready delayed 5 cycles:
  - `stall` and `mem_req_valid` stay high for all 5 cycles with a stable address;
  - a later load of 0x200 misses, confirming no-allocate.
- Reset during RD_WAIT:
  - `mem_req_valid=0` and `stall=0`;
  - a subsequent stray `mem_rvalid` is ignored;
  - a load of 0x100 misses.
